// File: rtl/datamem_lsu.sv
// Byte/half/word data memory behind a valid/ready request port with a fixed RD_LAT response pipe.
// Define DATAMEM_INIT_EN to compile in the post-reset zero-fill sweep (INIT -> RUN FSM).
module datamem_lsu #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH) + 2,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int LAST  = RD_LAT - 1;

  typedef struct packed {
    logic       err;
    logic       load;
    logic       uns;
    logic [1:0] size;
    logic [1:0] lane;
  } meta_t;

  logic [31:0]      mem [DEPTH];
  logic             accept;
  logic [IDX_W-1:0] idx;
  logic             err;
  logic [3:0]       lane_be;
  logic [31:0]      lane_data;
  logic             sweep;
  logic [IDX_W-1:0] sweep_idx;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  meta_t            meta_in;

  // Handshake: a request transfers on any rising edge where req_valid && req_ready;
  // responses cannot be stalled, so rsp_valid is a single-cycle pulse per transfer.
  assign accept = req_valid && req_ready;
  assign idx    = req_addr[ADDR_W-1:2];

  always_comb begin
    err       = 1'b0;
    lane_be   = 4'h0;
    lane_data = req_wdata;
    case (req_size)
      2'b00: begin
        lane_be   = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        err       = req_addr[0];
        lane_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        err     = |req_addr[1:0];
        lane_be = 4'hF;
      end
      default: err = 1'b1;
    endcase
  end

`ifdef DATAMEM_INIT_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t           state, state_next;
  logic [IDX_W-1:0] init_cnt;
  logic             ready_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) init_cnt <= init_cnt + IDX_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    ready_int  = 1'b0;
    sweep      = 1'b0;
    case (state)
      INIT: begin
        sweep = 1'b1;
        if (init_cnt == IDX_W'(DEPTH - 1)) state_next = RUN;
      end
      RUN: ready_int = 1'b1;
      default: state_next = INIT;
    endcase
  end

  assign sweep_idx = init_cnt;
  assign req_ready = ready_int;
  assign init_done = ready_int;
`else
  logic ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  assign sweep     = 1'b0;
  assign sweep_idx = '0;
  assign req_ready = ready_q;
  assign init_done = ready_q;
`endif

  assign wr_en   = sweep || (accept && req_we && !err);
  assign wr_idx  = sweep ? sweep_idx : idx;
  assign wr_be   = sweep ? 4'hF : lane_be;
  assign wr_data = sweep ? 32'h0 : lane_data;

  always_comb begin
    meta_in      = '0;
    meta_in.err  = err;
    meta_in.load = !req_we;
    meta_in.uns  = req_unsigned;
    meta_in.size = req_size;
    meta_in.lane = req_addr[1:0];
  end

  logic [RD_LAT-1:0] pipe_v;
  meta_t             pipe_m [RD_LAT];
  logic [31:0]       pipe_d [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_m[i] <= '0;
    end else begin
      pipe_v[0] <= accept;
      if (accept) pipe_m[0] <= meta_in;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_m[i] <= pipe_m[i-1];
      end
    end
  end

  // Array port: lane-masked write plus read-first registered read on the same edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
    if (accept) pipe_d[0] <= mem[idx];
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end

  meta_t       fin_m;
  logic [31:0] fin_d;
  logic [7:0]  lane8;
  logic [15:0] half16;

  always_comb begin
    fin_m  = pipe_m[LAST];
    fin_d  = pipe_d[LAST];
    half16 = fin_m.lane[1] ? fin_d[31:16] : fin_d[15:0];
    case (fin_m.lane)
      2'd0:    lane8 = fin_d[7:0];
      2'd1:    lane8 = fin_d[15:8];
      2'd2:    lane8 = fin_d[23:16];
      default: lane8 = fin_d[31:24];
    endcase
    rsp_rdata = 32'h0;
    if (pipe_v[LAST] && fin_m.load && !fin_m.err) begin
      case (fin_m.size)
        2'b00:   rsp_rdata = {{24{!fin_m.uns && lane8[7]}}, lane8};
        2'b01:   rsp_rdata = {{16{!fin_m.uns && half16[15]}}, half16};
        default: rsp_rdata = fin_d;
      endcase
    end
  end

  assign rsp_valid = pipe_v[LAST];
  assign rsp_err   = pipe_v[LAST] && fin_m.err;
endmodule

// File: tb/tb_datamem_lsu.sv
// Bench for datamem_lsu: drives RD_LAT=1 and RD_LAT=3 instances in lockstep against a byte-array model.
// Honours DATAMEM_INIT_EN for the reset-sweep expectations.
module tb_datamem_lsu;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 12;
`ifdef DATAMEM_INIT_EN
  localparam int EXP_READY_CYC = DEPTH;
`else
  localparam int EXP_READY_CYC = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [31:0]       req_wdata = '0;
  logic              req_ready_l1, req_ready_l3;
  logic              rsp_valid_l1, rsp_valid_l3;
  logic [31:0]       rsp_rdata_l1, rsp_rdata_l3;
  logic              rsp_err_l1, rsp_err_l3;
  logic              init_done_l1, init_done_l3;

  datamem_lsu #(.DEPTH(DEPTH), .RD_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_l1),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_l1), .rsp_rdata(rsp_rdata_l1), .rsp_err(rsp_err_l1),
    .init_done(init_done_l1)
  );

  datamem_lsu #(.DEPTH(DEPTH), .RD_LAT(3)) dut_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_l3),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_l3), .rsp_rdata(rsp_rdata_l3), .rsp_err(rsp_err_l3),
    .init_done(init_done_l3)
  );

  // clock/reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem_m [1 << ADDR_W];
  logic [32:0] exp_q1[$];
  logic [32:0] exp_q3[$];
  int          acc_q1[$];
  int          acc_q3[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: memory as a flat little-endian byte array
  function automatic logic [32:0] model_op(input logic we, input logic [ADDR_W-1:0] addr,
                                           input logic [1:0] size, input logic uns,
                                           input logic [31:0] wdata);
    int          nb;
    int          a;
    logic [31:0] v;
    if (size == 2'b11 || (size == 2'b01 && addr % 2 != 0) || (size == 2'b10 && addr % 4 != 0))
      return {1'b1, 32'h0};
    nb = 1 << size;
    a  = int'(addr);
    if (we) begin
      for (int k = 0; k < nb; k++) mem_m[a + k] = wdata[8*k +: 8];
      return {1'b0, 32'h0};
    end
    v = 32'h0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = mem_m[a + k];
    if (!uns && nb < 4 && v[8*nb-1])
      for (int bit_i = 8*nb; bit_i < 32; bit_i++) v[bit_i] = 1'b1;
    return {1'b0, v};
  endfunction

  // driver: present one request at posedge+1, hold it across one accepting edge
  task automatic issue(input logic we, input int addr, input int size, input logic uns,
                       input logic [31:0] wdata);
    int          n;
    logic [32:0] e;
    n = 0;
    while (!(req_ready_l1 && req_ready_l3) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    assert (req_ready_l1 && req_ready_l3) else begin
      failures++;
      $error("FAIL ready_timeout got=%0b%0b exp=11", req_ready_l1, req_ready_l3);
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = ADDR_W'(addr);
    req_size     = 2'(size);
    req_unsigned = uns;
    req_wdata    = wdata;
    e = model_op(we, ADDR_W'(addr), 2'(size), uns, wdata);
    exp_q1.push_back(e); acc_q1.push_back(cyc);
    exp_q3.push_back(e); acc_q3.push_back(cyc);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!(req_ready_l1 && req_ready_l3) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
  endtask

  // scoreboard: each response is popped against its expected entry and accept cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid_l1) begin
        checks++;
        assert (exp_q1.size() > 0) else begin
          failures++;
          $error("FAIL stale_rsp_l1 got=%h exp=none", rsp_rdata_l1);
        end
        if (exp_q1.size() > 0) begin
          logic [32:0] e;
          int a;
          e = exp_q1.pop_front(); a = acc_q1.pop_front();
          check("rdata_l1", rsp_rdata_l1, e[31:0]);
          check("err_l1", 32'(rsp_err_l1), 32'(e[32]));
          check("lat_l1", 32'(cyc - a), 32'd1);
        end
      end
      if (rsp_valid_l3) begin
        checks++;
        assert (exp_q3.size() > 0) else begin
          failures++;
          $error("FAIL stale_rsp_l3 got=%h exp=none", rsp_rdata_l3);
        end
        if (exp_q3.size() > 0) begin
          logic [32:0] e;
          int a;
          e = exp_q3.pop_front(); a = acc_q3.pop_front();
          check("rdata_l3", rsp_rdata_l3, e[31:0]);
          check("err_l3", 32'(rsp_err_l3), 32'(e[32]));
          check("lat_l3", 32'(cyc - a), 32'd3);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] d;
    for (int i = 0; i < (1 << ADDR_W); i++) mem_m[i] = 8'h00;

    // reset state
    idle(3);
    check("rst_ready", {30'h0, req_ready_l1, req_ready_l3}, 32'h0);
    check("rst_done", {30'h0, init_done_l1, init_done_l3}, 32'h0);
    check("rst_rsp", {29'h0, rsp_valid_l1, rsp_valid_l3, rsp_err_l1}, 32'h0);
    check("rst_rdata", rsp_rdata_l1 | rsp_rdata_l3, 32'h0);
    rst = 1'b0;
    wait_ready(n);
    check("ready_cycles", 32'(n), 32'(EXP_READY_CYC));
    check("init_done", {30'h0, init_done_l1, init_done_l3}, 32'h3);

`ifdef DATAMEM_INIT_EN
    issue(1'b0, 'h3FC, 2, 1'b0, 32'h0);
`else
    issue(1'b1, 'h3FC, 2, 1'b0, 32'h0);
    issue(1'b0, 'h3FC, 2, 1'b0, 32'h0);
`endif
    for (int w = 0; w < 32; w++) issue(1'b1, w * 4, 2, 1'b0, 32'h0);

    // byte/half extension
    issue(1'b1, 'h10, 2, 1'b0, 32'h80FF7F01);
    issue(1'b0, 'h11, 0, 1'b0, 32'h0);
    issue(1'b0, 'h12, 0, 1'b0, 32'h0);
    issue(1'b0, 'h12, 0, 1'b1, 32'h0);
    issue(1'b0, 'h12, 1, 1'b0, 32'h0);
    issue(1'b0, 'h12, 1, 1'b1, 32'h0);
    issue(1'b0, 'h13, 0, 1'b1, 32'h0);

    // partial stores
    issue(1'b1, 'h20, 2, 1'b0, 32'h11223344);
    issue(1'b1, 'h21, 0, 1'b0, 32'h000000AA);
    issue(1'b1, 'h22, 1, 1'b0, 32'h0000BEEF);
    issue(1'b0, 'h20, 2, 1'b0, 32'h0);

    // misaligned / illegal
    issue(1'b1, 'h30, 2, 1'b0, 32'hCAFE1234);
    issue(1'b1, 'h40, 2, 1'b0, 32'h5A5A0F0F);
    issue(1'b1, 'h31, 1, 1'b0, 32'h0000DEAD);
    issue(1'b1, 'h42, 2, 1'b0, 32'hFFFFFFFF);
    issue(1'b0, 'h31, 1, 1'b0, 32'h0);
    issue(1'b0, 'h40, 3, 1'b0, 32'h0);
    issue(1'b1, 'h40, 3, 1'b0, 32'h12345678);
    issue(1'b0, 'h30, 2, 1'b0, 32'h0);
    issue(1'b0, 'h40, 2, 1'b0, 32'h0);

    // back-to-back alternating sw/lw on one word
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      issue(1'b1, 'h50, 2, 1'b0, d);
      issue(1'b0, 'h50, 2, 1'b0, 32'h0);
    end
    idle(4);

    // randomized traffic within the pre-cleared region
    for (int i = 0; i < 200; i++) begin
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom);
      idle(int'($urandom_range(0, 2)));
    end

    n = 0;
    while ((exp_q1.size() > 0 || exp_q3.size() > 0) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("drain", 32'(exp_q1.size() + exp_q3.size()), 32'h0);

    // reset with loads in flight
    issue(1'b0, 'h10, 2, 1'b0, 32'h0);
    issue(1'b0, 'h20, 2, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {30'h0, rsp_valid_l1, rsp_valid_l3}, 32'h0);
    exp_q1.delete(); acc_q1.delete();
    exp_q3.delete(); acc_q3.delete();
    idle(2);
    check("rst_mid_done", {30'h0, init_done_l1, init_done_l3}, 32'h0);
    check("rst_mid_ready", {30'h0, req_ready_l1, req_ready_l3}, 32'h0);
    rst = 1'b0;
    wait_ready(n);
    check("reready_cycles", 32'(n), 32'(EXP_READY_CYC));
`ifdef DATAMEM_INIT_EN
    for (int i = 0; i < (1 << ADDR_W); i++) mem_m[i] = 8'h00;
    issue(1'b0, 'h10, 2, 1'b0, 32'h0);
    issue(1'b0, 'h20, 2, 1'b0, 32'h0);
`endif
    issue(1'b1, 'h60, 2, 1'b0, 32'h87654321);
    issue(1'b0, 'h60, 1, 1'b0, 32'h0);
    issue(1'b0, 'h63, 0, 1'b0, 32'h0);
    idle(6);
    check("final_drain", 32'(exp_q1.size() + exp_q3.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
